// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner and fetch FIFO towards decode with delay-slot redirects, halt and misalignment detection
module instr_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_instr,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        halted,
  output logic        addr_error
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  typedef enum logic [1:0] {RUN, HALTING, HALTED, ERROR} state_t;
  state_t state;
  logic [31:0] pc;
  logic [31:0] mem_i [DEPTH];
  logic [31:0] mem_p [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count, left;
  logic pop, redir, push;
  assign imem_address = pc;
  assign instr_valid = count != '0;
  assign instr = mem_i[rd_ptr];
  assign instr_pc = mem_p[rd_ptr];
  assign pop = instr_valid && instr_ready;
  assign left = count - (AW+1)'(pop);
  assign redir = pop && redirect_valid && state == RUN;
  // on a redirect only the delay slot may be pushed, and only when nothing survives the pop
  assign push = state == RUN && (redir ? left == '0 : left < FULL);
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_VECTOR;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      state <= RUN;
      halted <= 1'b0;
      addr_error <= 1'b0;
    end else begin
      if (push) begin
        mem_i[wr_ptr] <= imem_instr;
        mem_p[wr_ptr] <= pc;
      end
      if (redir) begin
        // the delay slot ends up at rd_ptr+1 whether it was retained or just pushed
        pc <= redirect_target;
        rd_ptr <= rd_ptr + AW'(1);
        wr_ptr <= rd_ptr + AW'(2);
        count <= (AW+1)'(1);
        state <= redirect_target[1:0] != 2'b00 ? ERROR : redirect_target == 32'h0 ? HALTING : RUN;
        addr_error <= addr_error | (redirect_target[1:0] != 2'b00);
      end else begin
        if (push) begin
          pc <= pc + 32'd4;
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        count <= count + (AW+1)'(push) - (AW+1)'(pop);
        if (state == HALTING && left == '0) begin
          state <= HALTED;
          halted <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: scenario table driving a program-order scoreboard of delivered PCs
module tb_instr_fetch_unit;
  localparam logic [31:0] RV = 32'hBFC00000;
  logic clk = 1'b0, reset = 1'b1;
  logic [31:0] imem_address, imem_instr, instr, instr_pc, redirect_target;
  logic instr_valid, instr_ready, redirect_valid, halted, addr_error;
  int total = 0, bad = 0;
  instr_fetch_unit dut (
    .clk(clk), .reset(reset), .imem_address(imem_address), .imem_instr(imem_instr),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .halted(halted), .addr_error(addr_error)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] memw(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A5A5A;
  endfunction
  assign imem_instr = memw(imem_address);
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic do_reset();
    reset = 1'b1;
    instr_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = '0;
    repeat (2) @(negedge clk);
    check("rst_valid", instr_valid, 0);
    check("rst_halted", halted, 0);
    check("rst_err", addr_error, 0);
    check("rst_addr", imem_address, RV);
    reset = 1'b0;
  endtask
  // kind: 0 = ordinary branch, 1 = halt (target 0), 2 = misaligned target
  typedef struct {
    int stall;
    int pct;
    logic [31:0] br;
    logic [31:0] tgt;
    int npops;
    int kind;
  } vec_t;
  vec_t vt[8];
  logic [31:0] q[$];
  initial begin
    vec_t v;
    logic [31:0] p;
    logic after, tk, taken, ds_pending, seen, rdy;
    int gap, c;
    vt[0] = '{10, 100, RV + 32'h08, RV + 32'h40, 8, 0};
    vt[1] = '{0, 100, RV + 32'h08, RV + 32'h40, 8, 0};
    vt[2] = '{0, 100, RV + 32'h0C, 32'h0, 20, 1};
    vt[3] = '{6, 100, RV + 32'h04, 32'h0, 20, 1};
    vt[4] = '{0, 50, RV + 32'h08, 32'hFFFFFFF8, 10, 0};
    vt[5] = '{2, 70, RV + 32'h14, RV + 32'h80, 12, 0};
    vt[6] = '{0, 100, RV + 32'h08, RV + 32'h42, 20, 2};
    vt[7] = '{3, 60, RV + 32'h10, RV + 32'h42, 20, 2};
    instr_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = '0;
    @(negedge clk);
    for (int s = 0; s < 8; s++) begin
      v = vt[s];
      q.delete();
      p = RV;
      after = 1'b0;
      tk = 1'b0;
      for (int i = 0; i < v.npops; i++) begin
        q.push_back(p);
        if (after) begin
          after = 1'b0;
          if (v.kind != 0) break;
          p = v.tgt;
        end else if (p == v.br && !tk) begin
          tk = 1'b1;
          after = 1'b1;
          p = p + 32'd4;
        end else p = p + 32'd4;
      end
      do_reset();
      taken = 1'b0;
      ds_pending = 1'b0;
      seen = 1'b0;
      gap = 0;
      c = 0;
      while (q.size() > 0 && c < 300) begin
        if (c == v.stall && v.stall >= 5) begin
          check("sat_addr", imem_address, RV + 32'h10);
          check("sat_valid", instr_valid, 1);
        end
        if (instr_valid) begin
          seen = 1'b1;
          gap = 0;
        end else if (seen) begin
          gap++;
          if (gap > 1 && v.pct == 100) check("bubble", gap, 1);
        end
        rdy = (c >= v.stall) && ($urandom_range(99) < v.pct);
        // a redirect offered without a pop must be ignored; target 2 would raise addr_error
        redirect_valid = 1'b1;
        redirect_target = 32'h2;
        if (rdy && instr_valid) begin
          check("pc", instr_pc, q[0]);
          check("instr", instr, memw(q[0]));
          if (ds_pending) begin
            ds_pending = 1'b0;
            if (v.kind != 0) redirect_target = RV + 32'h100;
            else redirect_valid = 1'b0;
          end else if (!taken && q[0] == v.br) begin
            taken = 1'b1;
            ds_pending = 1'b1;
            redirect_target = v.tgt;
          end else redirect_valid = 1'b0;
          void'(q.pop_front());
        end
        instr_ready = rdy;
        @(negedge clk);
        c++;
      end
      if (q.size() > 0) check("timeout", q.size(), 0);
      if (v.kind == 0) begin
        redirect_valid = 1'b0;
        check("no_halt", halted, 0);
        check("no_err", addr_error, 0);
      end else begin
        instr_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_target = RV;
        repeat (3) @(negedge clk);
        check("end_valid", instr_valid, 0);
        check("end_halted", halted, v.kind == 1);
        check("end_err", addr_error, v.kind == 2);
        check("end_addr", imem_address, v.kind == 1 ? 32'h0 : v.tgt);
        repeat (5) @(negedge clk);
        check("hold_addr", imem_address, v.kind == 1 ? 32'h0 : v.tgt);
        check("hold_valid", instr_valid, 0);
      end
    end
    check("pre_err", addr_error, 1);
    redirect_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("mid_addr", imem_address, RV);
    check("mid_valid", instr_valid, 0);
    check("mid_err", addr_error, 0);
    check("mid_halted", halted, 0);
    reset = 1'b0;
    instr_ready = 1'b0;
    @(negedge clk);
    check("first_valid", instr_valid, 1);
    check("first_pc", instr_pc, RV);
    check("first_instr", instr, memw(RV));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
